fb_rect_fill: RTL and testbench



---
 rtl/fb_rect_fill.sv | 125 ++++++++++++
 tb/tb_fb_rect_fill.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - rectangle fill command to single-pixel framebuffer write stream
// Clips each rectangle to the screen and emits one row-major pixel write per cycle.
module fb_rect_fill #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [9:0]  cmd_y,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done
);
  localparam logic [10:0] WIDTH_11  = 11'(WIDTH);
  localparam logic [10:0] HEIGHT_11 = 11'(HEIGHT);
  localparam logic [18:0] WIDTH_19  = 19'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t      state_q;
  logic [9:0]  x_q, y_q, w_q, h_q;
  logic [7:0]  color_q;
  logic [9:0]  cx_q, cy_q;
  logic [10:0] x_end_q, y_end_q;
  logic [18:0] row_base_q;
  logic [18:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        wr_en_q, busy_q, done_q;

  logic [10:0] x_sum, y_sum, x_end_d, y_end_d;
  logic [18:0] row_base_d, row_next_d, addr_next_d;
  logic [9:0]  cx_d, cy_d;
  logic        empty_rect, last_col, last_row;

  // Clip bounds are exclusive; 11 bits hold x+w without wrapping.
  assign x_sum      = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum      = {1'b0, y_q} + {1'b0, h_q};
  assign x_end_d    = (x_sum > WIDTH_11)  ? WIDTH_11  : x_sum;
  assign y_end_d    = (y_sum > HEIGHT_11) ? HEIGHT_11 : y_sum;
  assign row_base_d = {9'd0, y_q} * WIDTH_19;
  assign empty_rect = (w_q == 10'd0) | (h_q == 10'd0) |
                      ({1'b0, x_q} >= WIDTH_11) | ({1'b0, y_q} >= HEIGHT_11);

  assign last_col    = ({1'b0, cx_q} == (x_end_q - 11'd1));
  assign last_row    = ({1'b0, cy_q} == (y_end_q - 11'd1));
  assign cx_d        = last_col ? x_q : (cx_q + 10'd1);
  assign cy_d        = last_col ? (cy_q + 10'd1) : cy_q;
  assign row_next_d  = last_col ? (row_base_q + WIDTH_19) : row_base_q;
  assign addr_next_d = row_next_d + {9'd0, cx_d};

  assign cmd_ready = (state_q == S_IDLE) & ~rst;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // cx/cy always name the pixel currently presented on the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          x_end_q    <= x_end_d;
          y_end_q    <= y_end_d;
          cx_q       <= x_q;
          cy_q       <= y_q;
          row_base_q <= row_base_d;
          if (empty_rect) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= row_base_d + {9'd0, x_q};
            wr_data_q <= color_q;
            state_q   <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (last_col && last_row) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            row_base_q <= row_next_d;
            wr_addr_q  <= addr_next_d;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - self-checking bench for fb_rect_fill
// A small-screen second instance covers the full-screen fill within a short run.
module tb_fb_rect_fill;
  typedef struct {
    logic [9:0] x, y, w, h;
    logic [7:0] c;
    int         n;
    int         first;
    int         last;
  } vec_t;

  typedef struct packed {
    logic [18:0] a;
    logic [7:0]  d;
  } px_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [7:0]  cmd_color = '0;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en, busy, done;

  logic        f_valid = 1'b0;
  logic        f_ready;
  logic [9:0]  f_x = '0, f_y = '0, f_w = '0, f_h = '0;
  logic [7:0]  f_color = '0;
  logic [18:0] f_addr;
  logic [7:0]  f_data;
  logic        f_en, f_busy, f_done;

  int  n_checks = 0;
  int  n_err = 0;
  px_t exp_q[$];
  px_t sb_e;

  always #5 clk = ~clk;

  fb_rect_fill dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
  );

  fb_rect_fill #(.WIDTH(64), .HEIGHT(48)) dut_small (
    .clk(clk), .rst(rst), .cmd_valid(f_valid), .cmd_ready(f_ready),
    .cmd_x(f_x), .cmd_y(f_y), .cmd_w(f_w), .cmd_h(f_h), .cmd_color(f_color),
    .wr_addr(f_addr), .wr_data(f_data), .wr_en(f_en), .busy(f_busy), .done(f_done)
  );

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: visit every requested pixel, keep the on-screen ones.
  task automatic push_model(input vec_t v);
    int x0, y0, w0, h0;
    x0 = int'(v.x); y0 = int'(v.y); w0 = int'(v.w); h0 = int'(v.h);
    for (int yy = y0; yy < y0 + h0 && yy < 480; yy++)
      for (int xx = x0; xx < x0 + w0 && xx < 640; xx++)
        exp_q.push_back('{a: 19'(yy * 640 + xx), d: v.c});
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      chk("sb_range", (int'(wr_addr) < 307200) ? 1 : 0, 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_extra_write: got addr %0d, required no write", wr_addr);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_addr", int'(wr_addr), int'(sb_e.a));
        chk("sb_data", int'(wr_data), int'(sb_e.d));
      end
    end
  end

  task automatic drive_cmd(input vec_t v);
    cmd_x = v.x; cmd_y = v.y; cmd_w = v.w; cmd_h = v.h; cmd_color = v.c;
    cmd_valid = 1'b1;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int n, first_cyc, dcyc, bcnt, dcnt, fa, la;
    bit fin;
    n = 0; first_cyc = -1; dcyc = -1; bcnt = 0; dcnt = 0; fa = -1; la = -1; fin = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_before"}, int'(cmd_ready), 1);
    push_model(v);
    drive_cmd(v);
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cmd_valid = 1'b0;
      if (wr_en) begin
        n++;
        if (first_cyc < 0) begin first_cyc = cyc; fa = int'(wr_addr); end
        la = int'(wr_addr);
      end
      if (busy) bcnt++;
      if (done) begin dcnt++; if (dcyc < 0) dcyc = cyc; end
      if (dcyc >= 0 && cyc == dcyc + 1) begin
        chk({tag, "_ready_after"}, int'(cmd_ready), 1);
        fin = 1'b1;
      end
    end
    chk({tag, "_finished"}, int'(fin), 1);
    chk({tag, "_writes"}, n, v.n);
    chk({tag, "_done_cycle"}, dcyc, v.n + 2);
    chk({tag, "_busy_cycles"}, bcnt, v.n + 2);
    chk({tag, "_done_pulses"}, dcnt, 1);
    if (v.n > 0) begin
      chk({tag, "_first_cycle"}, first_cyc, 2);
      chk({tag, "_first_addr"}, fa, v.first);
      chk({tag, "_last_addr"}, la, v.last);
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v, v2;
    int   cnt, dc, we, nxt, bad, first, dcyc, bc;
    int   wq[$];
    int   dq[$];
    int   exp_w[5];
    int   exp_d[2];
    bit   fin;

    vecs[0] = '{10'd10,   10'd5,    10'd2,    10'd2,    8'hA5, 4,   3210,   3851};
    vecs[1] = '{10'd638,  10'd479,  10'd4,    10'd3,    8'h5A, 2,   307198, 307199};
    vecs[2] = '{10'd7,    10'd9,    10'd0,    10'd5,    8'h01, 0,   -1,     -1};
    vecs[3] = '{10'd3,    10'd3,    10'd5,    10'd0,    8'h02, 0,   -1,     -1};
    vecs[4] = '{10'd640,  10'd0,    10'd5,    10'd5,    8'h03, 0,   -1,     -1};
    vecs[5] = '{10'd0,    10'd480,  10'd5,    10'd5,    8'h04, 0,   -1,     -1};
    vecs[6] = '{10'd100,  10'd200,  10'd3,    10'd2,    8'h11, 6,   128100, 128742};
    vecs[7] = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 8'h22, 0,   -1,     -1};
    vecs[8] = '{10'd600,  10'd470,  10'd100,  10'd20,   8'hC3, 400, 301400, 307199};
    vecs[9] = '{10'd5,    10'd0,    10'd1,    10'd1,    8'hFF, 1,   5,      5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_ready_small", int'(f_ready), 1);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Reset partway through a 100x100 fill.
    v = '{10'd0, 10'd0, 10'd100, 10'd100, 8'h00, 0, -1, -1};
    push_model(v);
    @(negedge clk);
    drive_cmd(v);
    cnt = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cmd_valid = 1'b0;
      if (wr_en) cnt++;
      if (cnt == 50) break;
    end
    chk("abort_writes_before", cnt, 50);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    rst = 1'b0;
    exp_q.delete();
    dc = 0; we = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done) dc++;
      if (wr_en) we++;
    end
    chk("abort_no_done", dc, 0);
    chk("abort_no_writes", we, 0);
    chk("abort_ready", int'(cmd_ready), 1);
    v = '{10'd0, 10'd0, 10'd1, 10'd1, 8'h3C, 1, 0, 0};
    run_cmd(v, "after_abort");

    // cmd_valid held high with changing fields while a 3x1 command draws.
    v  = '{10'd20, 10'd10, 10'd3, 10'd1, 8'h77, 3, 6420, 6422};
    v2 = '{10'd1,  10'd2,  10'd2, 10'd1, 8'h99, 2, 1281, 1282};
    push_model(v);
    push_model(v2);
    exp_w = '{2, 3, 4, 8, 9};
    exp_d = '{5, 10};
    @(negedge clk);
    chk("held_ready_before", int'(cmd_ready), 1);
    drive_cmd(v);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (wr_en) wq.push_back(cyc);
      if (done) dq.push_back(cyc);
      if (cyc == 6) chk("held_ready_idle", int'(cmd_ready), 1);
      if (cyc <= 4) begin
        cmd_x = 10'($urandom_range(0, 600));
        cmd_y = 10'($urandom_range(0, 400));
        cmd_w = 10'($urandom_range(1, 50));
        cmd_h = 10'($urandom_range(1, 50));
        cmd_color = 8'($urandom_range(0, 255));
      end else if (cyc == 5) begin
        drive_cmd(v2);
      end else if (cyc == 7) begin
        cmd_valid = 1'b0;
      end
    end
    chk("held_num_writes", wq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wq.size()) chk($sformatf("held_write_cycle%0d", i), wq[i], exp_w[i]);
    chk("held_num_dones", dq.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < dq.size()) chk($sformatf("held_done_cycle%0d", i), dq[i], exp_d[i]);
    chk("held_drained", exp_q.size(), 0);

    // Full screen on the 64x48 instance.
    @(negedge clk);
    f_x = 10'd0; f_y = 10'd0; f_w = 10'd64; f_h = 10'd48; f_color = 8'h5E;
    f_valid = 1'b1;
    nxt = 0; bad = 0; cnt = 0; dc = 0; first = -1; dcyc = -1; bc = 0; fin = 1'b0;
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) f_valid = 1'b0;
      if (f_en) begin
        if (first < 0) first = cyc;
        if (int'(f_addr) != nxt || f_data != 8'h5E) bad++;
        nxt++;
        cnt++;
      end
      if (f_busy) bc++;
      if (f_done) begin dc++; if (dcyc < 0) dcyc = cyc; end
      if (dcyc >= 0 && cyc >= dcyc + 3) fin = 1'b1;
    end
    chk("full_finished", int'(fin), 1);
    chk("full_writes", cnt, 3072);
    chk("full_order_errors", bad, 0);
    chk("full_first_cycle", first, 2);
    chk("full_done_cycle", dcyc, 3074);
    chk("full_done_pulses", dc, 1);
    chk("full_busy_cycles", bc, 3074);
    chk("full_ready_after", int'(f_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
